// File: rtl/as_pack.sv
// Shared constants for the GPIO port: default sizes, register indices and
// the write-strobe FSM state type.
package as_pack;

    localparam int nr_gpios        = 8;
    localparam int gpio_addr_width = 3;

    // Word register indices on the request bus.
    localparam int REG_OUT  = 0;
    localparam int REG_DIR  = 1;
    localparam int REG_IN   = 2;
    localparam int REG_MASK = 3;
    localparam int REG_PEND = 4;

    typedef enum logic [1:0] {
        WR_IDLE   = 2'd0,
        WR_SETUP  = 2'd1,
        WR_STROBE = 2'd2
    } wr_state_e;

endpackage

// File: rtl/as_gpio_sync.sv
// Two-flop input synchronizer with a third stage for rising-edge detection.
// level_o is the second-stage value; rise_o flags a 0->1 seen on level_o.
module as_gpio_sync
    import as_pack::*;
#(
    parameter int WIDTH = nr_gpios
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] pins_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage2_q;
    logic [WIDTH-1:0] stage3_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stage1_q <= '0;
            stage2_q <= '0;
            stage3_q <= '0;
        end else begin
            stage1_q <= pins_i;
            stage2_q <= stage1_q;
            stage3_q <= stage2_q;
        end
    end

    assign level_o = stage2_q;
    assign rise_o  = stage2_q & ~stage3_q;

endmodule

// File: rtl/as_gpio_port.sv
// Memory-mapped GPIO port: OUT/DIR/IN/MASK/PEND registers, tri-state pins,
// and a SETUP/STROBE sequence that frames every OUT update with cs_o.
module as_gpio_port
    import as_pack::*;
#(
    parameter int NR_GPIOS = nr_gpios,
    parameter int ADDR_W   = gpio_addr_width
) (
    input  logic                clk_i,
    input  logic                rst_i,
    // Handshake: req_i is a one-cycle request, only taken while the write
    // FSM is idle; every taken request is answered by exactly one ack_o
    // pulse (next cycle, or in STROBE for OUT writes). Untaken requests get
    // no ack and must be re-issued.
    input  logic                req_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [63:0]         wdata_i,
    output logic [63:0]         rdata_o,
    output logic                ack_o,
    inout  wire  [NR_GPIOS-1:0] gpio_io,
    output logic                cs_o,
    output logic                irq_o,
    output wr_state_e           state_o
);

    wr_state_e state_q;
    wr_state_e state_d;

    logic [NR_GPIOS-1:0] out_q;
    logic [NR_GPIOS-1:0] dir_q;
    logic [NR_GPIOS-1:0] mask_q;
    logic [NR_GPIOS-1:0] pend_q;
    logic [NR_GPIOS-1:0] in_level;
    logic [NR_GPIOS-1:0] in_rise;
    logic [NR_GPIOS-1:0] wdata_g;
    logic [NR_GPIOS-1:0] w1c;

    logic        is_out;
    logic        is_dir;
    logic        is_in;
    logic        is_mask;
    logic        is_pend;
    logic        accept;
    logic        wr_out;
    logic        strobe;
    logic        ack_q;
    logic [63:0] rdata_q;
    logic [63:0] rd_val;

    assign wdata_g = wdata_i[NR_GPIOS-1:0];

    generate
        if (NR_GPIOS < 64) begin : g_wdata_hi
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^wdata_i[63:NR_GPIOS];
        end
    endgenerate

    assign is_out  = (addr_i == ADDR_W'(REG_OUT));
    assign is_dir  = (addr_i == ADDR_W'(REG_DIR));
    assign is_in   = (addr_i == ADDR_W'(REG_IN));
    assign is_mask = (addr_i == ADDR_W'(REG_MASK));
    assign is_pend = (addr_i == ADDR_W'(REG_PEND));

    // Requests arriving during SETUP/STROBE are dropped so OUT/DIR and the
    // pins stay frozen for the whole strobe frame.
    assign accept = req_i && (state_q == WR_IDLE);
    assign wr_out = accept && we_i && is_out;

    // ---------------- write FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= WR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- write FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WR_IDLE:   if (wr_out) state_d = WR_SETUP;
            WR_SETUP:  state_d = WR_STROBE;
            WR_STROBE: state_d = WR_IDLE;
            default:   state_d = WR_IDLE;
        endcase
    end

    // ---------------- write FSM: outputs ----------------
    always_comb begin
        strobe = 1'b0;
        if (state_q == WR_STROBE) strobe = 1'b1;
    end

    assign cs_o    = strobe;
    assign ack_o   = ack_q | strobe;
    assign state_o = state_q;

    // ---------------- read mux ----------------
    always_comb begin
        rd_val = '0;
        if (is_out)       rd_val[NR_GPIOS-1:0] = out_q;
        else if (is_dir)  rd_val[NR_GPIOS-1:0] = dir_q;
        else if (is_in)   rd_val[NR_GPIOS-1:0] = in_level;
        else if (is_mask) rd_val[NR_GPIOS-1:0] = mask_q;
        else if (is_pend) rd_val[NR_GPIOS-1:0] = pend_q;
    end

    assign w1c = (accept && we_i && is_pend) ? wdata_g : '0;

    // ---------------- registers ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_q   <= '0;
            dir_q   <= '0;
            mask_q  <= '0;
            pend_q  <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept && we_i) begin
                if (is_out)  out_q  <= wdata_g;
                if (is_dir)  dir_q  <= wdata_g;
                if (is_mask) mask_q <= wdata_g;
            end
            // A fresh edge outranks a same-cycle clear so it is never lost.
            pend_q  <= (pend_q & ~w1c) | in_rise;
            ack_q   <= accept && !wr_out;
            rdata_q <= (accept && !we_i) ? rd_val : '0;
        end
    end

    assign rdata_o = rdata_q;
    assign irq_o   = |(pend_q & mask_q);

    // ---------------- pins ----------------
    generate
        for (genvar i = 0; i < NR_GPIOS; i++) begin : g_pad
            assign gpio_io[i] = dir_q[i] ? out_q[i] : 1'bz;
        end
    endgenerate

    as_gpio_sync #(
        .WIDTH (NR_GPIOS)
    ) u_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .pins_i  (gpio_io),
        .level_o (in_level),
        .rise_o  (in_rise)
    );

endmodule

// File: tb/tb_as_gpio_port.sv
// Randomized bench for as_gpio_port: a cycle-level reference model predicts
// acks, strobes, read data and irq; a negedge monitor consumes the predictions.
module tb_as_gpio_port;

  localparam int N = 8;
  localparam logic [2:0] A_OUT  = 3'd0;
  localparam logic [2:0] A_DIR  = 3'd1;
  localparam logic [2:0] A_IN   = 3'd2;
  localparam logic [2:0] A_MASK = 3'd3;
  localparam logic [2:0] A_PEND = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [2:0]  addr  = '0;
  logic [63:0] wdata = '0;
  logic [63:0] rdata;
  logic        ack;
  logic        cs;
  logic        irq;
  as_pack::wr_state_e state;
  wire  [N-1:0] gpio;
  logic [N-1:0] ext_en  = '1;
  logic [N-1:0] ext_val = '0;

  for (genvar i = 0; i < N; i++) begin : g_ext
    assign gpio[i] = ext_en[i] ? ext_val[i] : 1'bz;
  end

  as_gpio_port #(.NR_GPIOS(N), .ADDR_W(3)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .req_i   (req),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .ack_o   (ack),
    .gpio_io (gpio),
    .cs_o    (cs),
    .irq_o   (irq),
    .state_o (state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct { int cyc; bit chk; logic [63:0] data; } ack_exp_t;
  typedef struct { int cyc; logic [N-1:0] val; logic [N-1:0] mask; } cs_exp_t;
  ack_exp_t exp_q[$];
  cs_exp_t  cs_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Pins are sampled at every edge; IN is the sample from two edges back and
  // a PEND bit sets when that sample is 1 and the one before it was 0.
  logic [N-1:0] m_out = '0, m_dir = '0, m_mask = '0, m_pend = '0;
  logic [N-1:0] hist [4];
  int m_busy = 0;

  always @(posedge clk) begin
    logic [1:0]   ix;
    logic [N-1:0] rise, w1c, wd;
    logic [63:0]  rv;
    cyc++;
    if (!rst_i) begin
      m_out = '0; m_dir = '0; m_mask = '0; m_pend = '0; m_busy = 0;
      for (int k = 0; k < 4; k++) hist[k] = '0;
    end else begin
      ix       = 2'(cyc);
      hist[ix] = (m_out & m_dir) | (ext_val & ext_en & ~m_dir);
      rise     = hist[ix - 2'd2] & ~hist[ix - 2'd3];
      w1c      = '0;
      wd       = wdata[N-1:0];
      if (m_busy > 0) begin
        m_busy--;
      end else if (req) begin
        rv = '0;
        case (addr)
          A_OUT:   rv[N-1:0] = m_out;
          A_DIR:   rv[N-1:0] = m_dir;
          A_IN:    rv[N-1:0] = hist[ix - 2'd2];
          A_MASK:  rv[N-1:0] = m_mask;
          A_PEND:  rv[N-1:0] = m_pend;
          default: rv = '0;
        endcase
        if (we && addr == A_OUT) begin
          m_out  = wd;
          m_busy = 2;
          exp_q.push_back('{cyc + 1, 1'b0, 64'd0});
          cs_q.push_back('{cyc + 1, wd, m_dir});
        end else begin
          if (we && addr == A_DIR)  m_dir  = wd;
          if (we && addr == A_MASK) m_mask = wd;
          if (we && addr == A_PEND) w1c    = wd;
          exp_q.push_back('{cyc, !we, rv});
        end
      end
      m_pend = (m_pend & ~w1c) | rise;
    end
  end

  // ---------------- monitor ----------------
  logic [N-1:0] prev_pins = '0;

  always @(negedge clk) begin
    ack_exp_t e;
    cs_exp_t  c;
    if (!rst_i) begin
      check("rst_ack", ack, 0);
      check("rst_cs", cs, 0);
      check("rst_irq", irq, 0);
      check("rst_rdata", rdata, 0);
      check("rst_state", state, 0);
    end else begin
      if (exp_q.size() == 0) begin
        check("ack_spurious", ack, 0);
      end else if (ack) begin
        e = exp_q.pop_front();
        check("ack_cycle", 64'(cyc), 64'(e.cyc));
        if (e.chk) check("rdata", rdata, e.data);
      end else if (exp_q[0].cyc <= cyc) begin
        check("ack_missing", ack, 1);
        void'(exp_q.pop_front());
      end
      if (cs_q.size() == 0) begin
        check("cs_spurious", cs, 0);
      end else if (cs) begin
        c = cs_q.pop_front();
        check("cs_cycle", 64'(cyc), 64'(c.cyc));
        check("pins_strobe", gpio & c.mask, c.val & c.mask);
        check("pins_setup", prev_pins & c.mask, c.val & c.mask);
      end else if (cs_q[0].cyc <= cyc) begin
        check("cs_missing", cs, 1);
        void'(cs_q.pop_front());
      end
      check("irq", irq, |(m_pend & m_mask));
    end
    prev_pins = gpio;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    ext_en = ~m_dir;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic issue(input logic w, input logic [2:0] a, input logic [63:0] d);
    req = 1'b1; we = w; addr = a; wdata = d;
    tick();
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2 rst_i = 1'b0;
    idle(3);
    rst_i = 1'b1;
    idle(2);

    // Reset values of every register.
    for (int a = 0; a < 5; a++) issue(1'b0, 3'(a), 64'd0);
    idle(1);

    // Single OUT write with all pins driven.
    issue(1'b1, A_DIR, 64'hFF);
    issue(1'b1, A_OUT, 64'h80);
    idle(4);

    // Back-to-back OUT writes; the two busy-cycle requests must be ignored.
    for (int v = 1; v <= 7; v++) begin
      issue(1'b1, A_OUT, 64'(v));
      issue(1'b1, A_OUT, 64'(v));
      issue(1'b1, A_OUT, 64'hF0 | 64'(v));
    end
    idle(2);
    issue(1'b0, A_OUT, 64'd0);

    // Mixed direction: low nibble driven, high nibble from outside.
    issue(1'b1, A_DIR, 64'h0F);
    issue(1'b1, A_OUT, 64'hA5);
    idle(2);
    ext_val = 8'hC0;
    idle(4);
    issue(1'b0, A_IN, 64'd0);
    issue(1'b0, A_OUT, 64'd0);

    // Edge capture, masking, W1C and the set-wins collision.
    issue(1'b1, A_DIR, 64'h00);
    ext_val = 8'h00;
    idle(5);
    issue(1'b1, A_PEND, 64'hFF);
    issue(1'b1, A_MASK, 64'h01);
    ext_val = 8'h01;
    idle(5);
    issue(1'b0, A_PEND, 64'd0);
    check("irq_after_edge", irq, 1);
    issue(1'b1, A_PEND, 64'h01);
    idle(1);
    check("irq_after_w1c", irq, 0);
    ext_val = 8'h00;
    idle(5);
    ext_val = 8'h01;
    idle(2);
    issue(1'b1, A_PEND, 64'h01);
    issue(1'b0, A_PEND, 64'd0);
    idle(1);

    // Unmapped read and writes to read-only / unmapped addresses.
    issue(1'b0, 3'd5, 64'd0);
    issue(1'b1, A_IN, 64'hFF);
    issue(1'b1, 3'd7, 64'hFF);
    for (int a = 0; a < 8; a++) issue(1'b0, 3'(a), 64'd0);

    // Randomized traffic, including requests while busy.
    repeat (250) begin
      if ($urandom_range(0, 3) == 0) ext_val = N'($urandom);
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), {$urandom, $urandom});
      idle($urandom_range(0, 2));
    end
    idle(5);

    // Reset in the middle of a strobe frame.
    issue(1'b1, A_DIR, 64'hFF);
    issue(1'b1, A_OUT, 64'h80);
    @(posedge clk);
    #1 rst_i = 1'b0;
    exp_q.delete();
    cs_q.delete();
    ext_en  = '1;
    ext_val = 8'h5A;
    #1;
    check("abort_cs", cs, 0);
    check("abort_ack", ack, 0);
    check("abort_pins", gpio, 8'h5A);
    idle(2);
    rst_i = 1'b1;
    idle(1);
    issue(1'b0, A_OUT, 64'd0);
    issue(1'b0, A_DIR, 64'd0);
    idle(5);

    check("ack_queue_drained", 64'(exp_q.size()), 0);
    check("cs_queue_drained", 64'(cs_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
